// File: rtl/uart_tx_engine_pkg.sv
// Shared definitions for the UART transmit engine.
//   K_W        : width of the bit-time divisor k
//   FRAME_BITS : fixed frame length (start + 7/8 data + parity/stop padding)
//   START/P8/P9/STOP : bit positions inside the frame shift register
//   build_frame() : forms the 11-bit frame from a byte and its format controls
package uart_tx_engine_pkg;

  localparam int K_W        = 19;
  localparam int FRAME_BITS = 11;

  localparam int START = 0;
  localparam int P8    = 8;
  localparam int P9    = 9;
  localparam int STOP  = 10;

  // Parity over 7 or 8 data bits; odd sense inverts the even result.
  function automatic logic frame_parity(input logic [7:0] d, input logic eight,
                                        input logic ohel);
    logic x;
    x = eight ? ^d : ^d[6:0];
    return ohel ? ~x : x;
  endfunction

  // Frame is LSB-first: the shift register emits bit 0 first.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d,
                                                        input logic eight,
                                                        input logic pen,
                                                        input logic ohel);
    logic [FRAME_BITS-1:0] f;
    logic par;
    par      = frame_parity(d, eight, ohel);
    f        = '1;
    f[START] = 1'b0;
    f[7:1]   = d[6:0];
    f[P8]    = eight ? d[7] : (pen ? par : 1'b1);
    f[P9]    = (eight && pen) ? par : 1'b1;
    f[STOP]  = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Bus between the CPU-side logic (master) and the transmit engine (slave).
//   doit  : Q of the external doit SR flop; high while a frame is in progress
//   load  : one-cycle write strobe; data/format are sampled with it
//   data, eight, pen, ohel : byte and format controls
//   k     : clocks per bit (0 behaves as 1)
//   tx    : serial line, idle high
//   done  : one-cycle pulse on the final bit-time boundary
// Handshake: load is a single-cycle strobe that is accepted only while doit=0;
// doit rises with the accepted load and falls after the done pulse, so
// load->done brackets one frame and there is no back-pressure path.
interface uart_tx_engine_if;
  import uart_tx_engine_pkg::*;

  logic           doit;
  logic           load;
  logic [7:0]     data;
  logic           eight;
  logic           pen;
  logic           ohel;
  logic [K_W-1:0] k;
  logic           tx;
  logic           done;

  modport master (output doit, load, data, eight, pen, ohel, k,
                  input  tx, done);
  modport slave  (input  doit, load, data, eight, pen, ohel, k,
                  output tx, done);
endinterface

// File: rtl/uart_tx_engine_bit_timer.sv
// Bit-time counter plus 4-bit bit counter for the transmit engine.
//   clk, rst : clock, async active-high reset
//   run      : count enable (frame in progress, not in the load cycle)
//   clr      : synchronous clear of both counters (idle or frame load)
//   k        : clocks per bit, 0 treated as 1
//   btu      : bit-time-up, high on the last clock of each bit
//   done     : btu on the stop bit
module uart_tx_engine_bit_timer
  import uart_tx_engine_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           clr,
  input  logic [K_W-1:0] k,
  output logic           btu,
  output logic           done
);

  logic [K_W-1:0] cnt;
  logic [3:0]     bit_cnt;
  logic [K_W-1:0] k_last;

  // k=0 and k=1 both compare against 0, so btu fires every cycle.
  assign k_last = (k == '0) ? '0 : k - K_W'(1);
  assign btu    = run && (cnt == k_last);
  assign done   = btu && (bit_cnt == 4'(STOP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (btu) begin
      cnt     <= '0;
      bit_cnt <= (bit_cnt == 4'(STOP)) ? 4'd0 : bit_cnt + 4'd1;
    end else if (run) begin
      cnt     <= cnt + K_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit shift engine: frames and serialises one byte per load.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of uart_tx_engine_if (doit, load, data, eight,
//              pen, ohel, k in; tx, done out)
// Load is captured into hold registers on the strobe edge and moved into the
// frame shift register one cycle later, which is when the start bit appears.
module uart_tx_engine
  import uart_tx_engine_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  uart_tx_engine_if.slave bus
);

  logic [7:0]            data_h;
  logic                  eight_h;
  logic                  pen_h;
  logic                  ohel_h;
  logic                  load_d1;
  logic [FRAME_BITS-1:0] sr;
  logic                  accept;
  logic                  btu;
  logic                  done_w;

  // A load arriving mid-frame is dropped; format inputs are only used via
  // the hold registers, so mid-frame changes cannot disturb the frame.
  assign accept = bus.load && !bus.doit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_h  <= '0;
      eight_h <= 1'b0;
      pen_h   <= 1'b0;
      ohel_h  <= 1'b0;
      load_d1 <= 1'b0;
    end else begin
      load_d1 <= accept;
      if (accept) begin
        data_h  <= bus.data;
        eight_h <= bus.eight;
        pen_h   <= bus.pen;
        ohel_h  <= bus.ohel;
      end
    end
  end

  uart_tx_engine_bit_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (bus.doit && !load_d1),
    .clr  (!bus.doit || load_d1),
    .k    (bus.k),
    .btu  (btu),
    .done (done_w)
  );

  // Idle (doit low) forces all ones, which also aborts a frame whose doit
  // was dropped externally. Shifting in 1s keeps the line high after stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '1;
    end else if (!bus.doit) begin
      sr <= '1;
    end else if (load_d1) begin
      sr <= build_frame(data_h, eight_h, pen_h, ohel_h);
    end else if (btu) begin
      sr <= {1'b1, sr[FRAME_BITS-1:1]};
    end
  end

  assign bus.tx   = sr[START];
  assign bus.done = done_w;

endmodule
